// File: rtl/dtcm_responder.sv
// Data TCM responder: byte-lane masked stores, registered right-aligned loads,
// and a post-reset clear sequencer that zeroes the array before raising ready.
module dtcm_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [1:0]  write_width,
  input  logic [31:0] addr_write,
  input  logic [31:0] write_data,
  input  logic [31:0] addr_read,
  input  logic [1:0]  read_width,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        misaligned_write,
  output logic        misaligned_read
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] WIDTH_SHORT = 2'b01;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t          state;
  logic [AW-1:0]   clear_ctr;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     rd_word;
  logic [1:0]      rd_off;
  logic [1:0]      rd_width;
  logic            rd_valid;

  logic [31:0]     wr_rel;
  logic [31:0]     rd_rel;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            wr_mis;
  logic            rd_mis;

  logic [AW-1:0]   mem_idx;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wdata;

  // BYTE is always aligned; SHORT needs an even address; WORD (and 2'b11) needs a word address.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
    case (width)
      WIDTH_BYTE:  is_misaligned = 1'b0;
      WIDTH_SHORT: is_misaligned = off[0];
      default:     is_misaligned = |off;
    endcase
  endfunction

  // Offsets beyond the array are dropped, so accesses wrap inside the array.
  assign wr_rel = addr_write - BASE_ADDR;
  assign rd_rel = addr_read  - BASE_ADDR;
  assign wr_idx = wr_rel[AW+1:2];
  assign rd_idx = rd_rel[AW+1:2];
  assign wr_mis = is_misaligned(write_width, addr_write[1:0]);
  assign rd_mis = is_misaligned(read_width,  addr_read[1:0]);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_rel[31:AW+2], wr_rel[1:0], rd_rel[31:AW+2], rd_rel[1:0]};

  // Single write port shared by the clear sequencer and LSU stores.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    mem_idx   = wr_idx;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (state == S_CLEAR) begin
      mem_idx   = clear_ctr;
      mem_be    = 4'b1111;
      mem_wdata = 32'h0;
    end else if (we && !wr_mis) begin
      case (write_width)
        WIDTH_BYTE: begin
          mem_be    = 4'b0001 << addr_write[1:0];
          mem_wdata = {4{write_data[7:0]}};
        end
        WIDTH_SHORT: begin
          mem_be    = addr_write[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{write_data[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = write_data;
        end
      endcase
    end
  end

  // NOTE: the array has no reset branch; the clear sequencer zeroes it, which keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_be[i]) begin
        mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    // Read-first: this samples the word before the same-edge write lands.
    rd_word <= mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_CLEAR;
      clear_ctr        <= '0;
      ready            <= 1'b0;
      misaligned_write <= 1'b0;
      misaligned_read  <= 1'b0;
      rd_off           <= 2'b00;
      rd_width         <= 2'b00;
      rd_valid         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_CLEAR: begin
          misaligned_write <= 1'b0;
          misaligned_read  <= 1'b0;
          rd_valid         <= 1'b0;
          clear_ctr        <= clear_ctr + 1'b1;
          if (clear_ctr == AW'(DEPTH_WORDS - 1)) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          misaligned_write <= we && wr_mis;
          misaligned_read  <= rd_mis;
          rd_valid         <= !rd_mis;
          rd_off           <= addr_read[1:0];
          rd_width         <= read_width;
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

  // Right-align the registered word; rd_valid forces zero during clear and on misaligned loads.
  logic [31:0] rd_shift;
  assign rd_shift = rd_word >> {rd_off, 3'b000};

  always_comb begin
    read_data = 32'h0;
    if (rd_valid) begin
      case (rd_width)
        WIDTH_BYTE:  read_data = {24'h0, rd_shift[7:0]};
        WIDTH_SHORT: read_data = {16'h0, rd_shift[15:0]};
        default:     read_data = rd_word;
      endcase
    end
  end

endmodule

// File: doc/dtcm_responder.md
Name: dtcm_responder

Overview:
- Data TCM memory block that answers the load/store unit's DTCM accesses in the 0x1000–0x4FFF region.
- Writes commit at the MEMEX-stage clock edge, using byte-lane masking derived from write width and address.
- Reads are registered, so data appears in WB one cycle after the address is presented. Read data is right-aligned and zero-extended; the LSU performs any sign extension.
- After reset, a clear sequencer zeroes the whole array before the block reports ready.

Parameters:
- BASE_ADDR, 32'h1000, byte address mapped to word 0.
- DEPTH_WORDS, 4096, number of 32-bit words (16 KiB).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  1  write strobe, already gated by the LSU address decode.
- write_width  input  2  store width: DATAWIDTH_BYTE=2'b00, DATAWIDTH_SHORT=2'b01, DATAWIDTH_WORD=2'b10.
- addr_write  input  32  store byte address.
- write_data  input  32  store data, right-aligned (byte in [7:0], short in [15:0]).
- addr_read  input  32  load byte address, presented in MEMEX.
- read_width  input  2  load width, same encoding as write_width.
- read_data  output  32  registered load data, valid in the cycle after addr_read.
- ready  output  1  high once the clear sequence is complete.
- misaligned_write  output  1  registered one-cycle pulse: a write was rejected.
- misaligned_read  output  1  registered flag aligned with read_data: the load was misaligned.

Behaviour:
- Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
  - Upper offset bits are ignored; the address wraps inside the array.
  - Lane offset = addr[1:0].
- States: CLEAR, RUN.
  - Reset (asynchronous, any time, including mid-CLEAR or mid-write) forces CLEAR and clear_ctr=0.
  - Reset values: ready=0, read_data=0, misaligned_write=0, misaligned_read=0.
  - CLEAR: write 32'h0 to word clear_ctr each cycle, then increment. When clear_ctr==DEPTH_WORDS-1 is written, go to RUN next edge and set ready=1. This takes exactly DEPTH_WORDS cycles after rst_n deasserts.
  - CLEAR: we is ignored, read_data stays 0, misaligned flags stay 0.
  - RUN: stays in RUN until reset.
- Write (RUN, we=1):
  - BYTE: lane addr[1:0] gets write_data[7:0].
  - SHORT: lanes {addr[1],0} and {addr[1],1} get write_data[15:0]; requires addr[0]=0.
  - WORD: all lanes get write_data; requires addr[1:0]=0.
  - Width 2'b11 is treated as WORD.
  - Misaligned write: no lane is written; misaligned_write=1 for the next cycle only.
  - Non-addressed lanes are unchanged.
- Read (RUN):
  - Every cycle, register the word at the read index, plus addr_read[1:0] and read_width.
  - Next cycle, read_data = stored word >> (8*offset) for BYTE, masked to [7:0]. For SHORT, offset is {addr[1],0}, masked to [15:0]. For WORD, the full word.
  - Upper bits are zero.
  - Misaligned read (same alignment rules as writes): read_data=0 and misaligned_read=1 in that cycle.
- Simultaneous read and write to the same word in the same cycle: read-first. read_data returns the pre-write contents. A load presented the cycle after a store sees the new data.
- No internal queue: one write and one read are accepted per cycle with no backpressure. ready is the only stall indication.

Test Plan:
- Reset release, idle → ready=0 for exactly 4096 cycles, then 1. Reading 0x1000 and 0x4FFC after ready returns 32'h0.
- Write WORD 32'hDEADBEEF @0x1004, then read BYTE @0x1006 → 32'h000000AD. Read SHORT @0x1004 → 32'h0000BEEF. Read WORD @0x1004 → 32'hDEADBEEF, one cycle after the address.
- Write BYTE 8'h5A @0x1007 over 32'hDEADBEEF → word reads 32'h5AADBEEF. Write SHORT 16'h1234 @0x1004 → 32'h5AAD1234.
- Write SHORT @0x1003 → misaligned_write pulses one cycle and memory is unchanged. Read WORD @0x1002 → read_data=0 with misaligned_read=1.
- Same-cycle write WORD 32'h11111111 and read WORD at 0x2000 (previously 32'h0) → read_data=32'h0. Read on the next cycle → 32'h11111111.
- Assert rst_n=0 during RUN, then mid-CLEAR at cycle 100 → outputs go to 0 immediately. After release, ready rises 4096 cycles later and all words read 0, including 0x2000.
